// File: rtl/sdram_arb_pkg.sv
// Shared types for the two-master SDRAM port arbiter.
package sdram_arb_pkg;

   localparam int NUM_MASTERS = 2;

   typedef logic [0:0] master_id_t;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } arb_state_t;

endpackage

// File: rtl/sdram_arb_id_fifo.sv
// In-order FIFO of master IDs for outstanding reads; push while full is
// accepted only when a pop happens in the same cycle.
module sdram_arb_id_fifo
   import sdram_arb_pkg::*;
#(
   parameter int DEPTH = 8,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk_clk,
   input  logic             reset_reset_n,
   input  logic             push,
   input  master_id_t       push_id,
   input  logic             pop,
   output master_id_t       pop_id,
   output logic             full,
   output logic             empty,
   output logic [PTR_W:0]   count
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   master_id_t       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign pop_id  = mem[rd_ptr];

   always_ff @(posedge clk_clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_id;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter with command lock sharing one SDRAM controller slave
// between the CPU data master (m0) and the DMA/video master (m1).
//
// state    | meaning
// UNLOCKED | grant chosen each cycle (single request, or tie -> not last_served)
// LOCKED   | slave stalled a presented command; grant frozen until accept
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int ADDR_W      = 25,
   parameter int DATA_W      = 32,
   parameter int MAX_PENDING = 8,
   localparam int CNT_W      = $clog2(MAX_PENDING) + 1
) (
   input  logic                  clk_clk,
   input  logic                  reset_reset_n,

   input  logic [ADDR_W-1:0]     m0_address,
   input  logic                  m0_read,
   input  logic                  m0_write,
   input  logic [DATA_W-1:0]     m0_writedata,
   input  logic [DATA_W/8-1:0]   m0_byteenable,
   output logic                  m0_waitrequest,
   output logic [DATA_W-1:0]     m0_readdata,
   output logic                  m0_readdatavalid,

   input  logic [ADDR_W-1:0]     m1_address,
   input  logic                  m1_read,
   input  logic                  m1_write,
   input  logic [DATA_W-1:0]     m1_writedata,
   input  logic [DATA_W/8-1:0]   m1_byteenable,
   output logic                  m1_waitrequest,
   output logic [DATA_W-1:0]     m1_readdata,
   output logic                  m1_readdatavalid,

   output logic [ADDR_W-1:0]     s_address,
   output logic                  s_read,
   output logic                  s_write,
   output logic [DATA_W-1:0]     s_writedata,
   output logic [DATA_W/8-1:0]   s_byteenable,
   input  logic                  s_waitrequest,
   input  logic [DATA_W-1:0]     s_readdata,
   input  logic                  s_readdatavalid,

   output logic [CNT_W-1:0]      pending,
   output logic                  err_orphan
);

   logic [NUM_MASTERS-1:0] req;
   arb_state_t             state;
   arb_state_t             state_nxt;
   master_id_t             lock_grant;
   master_id_t             lock_grant_nxt;
   master_id_t             last_served;
   master_id_t             last_served_nxt;
   master_id_t             grant;
   logic                   cmd_read;
   logic                   cmd_write;
   logic                   read_blocked;
   logic                   accept;

   logic                   fifo_push;
   logic                   fifo_pop;
   master_id_t             fifo_pop_id;
   logic                   fifo_full;
   logic                   fifo_empty;

   assign req = {m1_read | m1_write, m0_read | m0_write};

   always_comb begin
      grant = '0;
      if (state == LOCKED) begin
         grant = lock_grant;
      end else if (req[0] && req[1]) begin
         grant = ~last_served;
      end else if (req[1]) begin
         grant = 1'b1;
      end
   end

   assign cmd_read     = grant[0] ? m1_read  : m0_read;
   assign cmd_write    = grant[0] ? m1_write : m0_write;
   assign s_address    = grant[0] ? m1_address    : m0_address;
   assign s_writedata  = grant[0] ? m1_writedata  : m0_writedata;
   assign s_byteenable = grant[0] ? m1_byteenable : m0_byteenable;

   // A return in the same cycle frees a slot, so a full FIFO may still admit.
   assign read_blocked = cmd_read & fifo_full & ~s_readdatavalid;
   assign s_read       = reset_reset_n & cmd_read & ~read_blocked;
   assign s_write      = reset_reset_n & cmd_write;
   assign accept       = (s_read | s_write) & ~s_waitrequest;

   assign m0_waitrequest = ~(accept & (grant == 1'b0));
   assign m1_waitrequest = ~(accept & (grant == 1'b1));

   always_comb begin
      state_nxt       = state;
      lock_grant_nxt  = lock_grant;
      last_served_nxt = last_served;
      case (state)
         UNLOCKED: begin
            if ((s_read | s_write) & s_waitrequest) begin
               state_nxt      = LOCKED;
               lock_grant_nxt = grant;
            end
         end
         LOCKED: begin
            // A master dropping its command mid-stall must not wedge the port.
            if (accept || !(s_read || s_write)) begin
               state_nxt = UNLOCKED;
            end
         end
         default: begin
            state_nxt = UNLOCKED;
         end
      endcase
      if (accept) begin
         last_served_nxt = grant;
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state       <= UNLOCKED;
         lock_grant  <= '0;
         last_served <= 1'b1;
      end else begin
         state       <= state_nxt;
         lock_grant  <= lock_grant_nxt;
         last_served <= last_served_nxt;
      end
   end

   assign fifo_push = s_read & ~s_waitrequest;
   assign fifo_pop  = s_readdatavalid & ~fifo_empty;

   sdram_arb_id_fifo #(
      .DEPTH (MAX_PENDING)
   ) u_id_fifo (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .push          (fifo_push),
      .push_id       (grant),
      .pop           (fifo_pop),
      .pop_id        (fifo_pop_id),
      .full          (fifo_full),
      .empty         (fifo_empty),
      .count         (pending)
   );

   assign m0_readdata      = s_readdata;
   assign m1_readdata      = s_readdata;
   assign m0_readdatavalid = fifo_pop & (fifo_pop_id == 1'b0);
   assign m1_readdatavalid = fifo_pop & (fifo_pop_id == 1'b1);

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         err_orphan <= 1'b0;
      end else if (s_readdatavalid && fifo_empty) begin
         err_orphan <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: stimulus pushes expected slave
// commands and read returns into queues; a negedge monitor pops and compares.
module tb_sdram_port_arbiter;

   localparam int ADDR_W = 25;
   localparam int DATA_W = 32;
   localparam int BE_W   = DATA_W / 8;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic              wr;
      logic [DATA_W-1:0] wdata;
   } cmd_t;

   typedef struct {
      logic              mid;
      logic [DATA_W-1:0] data;
   } rd_t;

   logic              clk_clk = 1'b0;
   logic              reset_reset_n;
   logic [ADDR_W-1:0] m0_address, m1_address;
   logic              m0_read, m0_write, m1_read, m1_write;
   logic [DATA_W-1:0] m0_writedata, m1_writedata;
   logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
   logic              m0_waitrequest, m1_waitrequest;
   logic [DATA_W-1:0] m0_readdata, m1_readdata;
   logic              m0_readdatavalid, m1_readdatavalid;
   logic [ADDR_W-1:0] s_address;
   logic              s_read, s_write;
   logic [DATA_W-1:0] s_writedata;
   logic [BE_W-1:0]   s_byteenable;
   logic              s_waitrequest;
   logic [DATA_W-1:0] s_readdata;
   logic              s_readdatavalid;
   logic [3:0]        pending;
   logic              err_orphan;

   cmd_t exp_cmd[$];
   rd_t  exp_rd[$];
   cmd_t mon_cmd;
   rd_t  mon_rd;
   int   n_checks = 0;
   int   n_pass   = 0;

   sdram_port_arbiter dut (
      .clk_clk          (clk_clk),
      .reset_reset_n    (reset_reset_n),
      .m0_address       (m0_address),
      .m0_read          (m0_read),
      .m0_write         (m0_write),
      .m0_writedata     (m0_writedata),
      .m0_byteenable    (m0_byteenable),
      .m0_waitrequest   (m0_waitrequest),
      .m0_readdata      (m0_readdata),
      .m0_readdatavalid (m0_readdatavalid),
      .m1_address       (m1_address),
      .m1_read          (m1_read),
      .m1_write         (m1_write),
      .m1_writedata     (m1_writedata),
      .m1_byteenable    (m1_byteenable),
      .m1_waitrequest   (m1_waitrequest),
      .m1_readdata      (m1_readdata),
      .m1_readdatavalid (m1_readdatavalid),
      .s_address        (s_address),
      .s_read           (s_read),
      .s_write          (s_write),
      .s_writedata      (s_writedata),
      .s_byteenable     (s_byteenable),
      .s_waitrequest    (s_waitrequest),
      .s_readdata       (s_readdata),
      .s_readdatavalid  (s_readdatavalid),
      .pending          (pending),
      .err_orphan       (err_orphan)
   );

   always #5 clk_clk = ~clk_clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_clk);
      #1;
   endtask

   task automatic push_cmd(input logic [ADDR_W-1:0] a, input logic w, input logic [DATA_W-1:0] d);
      cmd_t c;
      c.addr  = a;
      c.wr    = w;
      c.wdata = d;
      exp_cmd.push_back(c);
   endtask

   task automatic push_rd(input logic mid, input logic [DATA_W-1:0] d);
      rd_t r;
      r.mid  = mid;
      r.data = d;
      exp_rd.push_back(r);
   endtask

   task automatic do_reset();
      reset_reset_n = 1'b0;
      m0_read  = 1'b1;
      m1_write = 1'b1;
      #3;
      check("rst_m0_wait", m0_waitrequest, 1);
      check("rst_m1_wait", m1_waitrequest, 1);
      check("rst_s_read", s_read, 0);
      check("rst_s_write", s_write, 0);
      check("rst_pending", pending, 0);
      check("rst_err_orphan", err_orphan, 0);
      check("rst_rdv", {m1_readdatavalid, m0_readdatavalid}, 0);
      m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
      s_waitrequest = 0; s_readdatavalid = 0;
      @(posedge clk_clk);
      #1;
      reset_reset_n = 1'b1;
   endtask

   // Monitor: every slave accept and every master read return is scored.
   always @(negedge clk_clk) begin
      if (reset_reset_n === 1'b1) begin
         if ((s_read | s_write) & ~s_waitrequest) begin
            if (exp_cmd.size() == 0) begin
               n_checks++;
               $display("FAIL cmd_unexpected: got addr 0x%0h wr %0b expected none", s_address, s_write);
            end else begin
               mon_cmd = exp_cmd.pop_front();
               check("cmd_addr", s_address, mon_cmd.addr);
               check("cmd_write", s_write, mon_cmd.wr);
               if (mon_cmd.wr) check("cmd_wdata", s_writedata, mon_cmd.wdata);
            end
         end
         if (m0_readdatavalid | m1_readdatavalid) begin
            if (exp_rd.size() == 0) begin
               n_checks++;
               $display("FAIL rd_unexpected: got rdv {m1,m0}=%0b%0b expected none", m1_readdatavalid, m0_readdatavalid);
            end else begin
               mon_rd = exp_rd.pop_front();
               check("rd_master", {m1_readdatavalid, m0_readdatavalid}, mon_rd.mid ? 2'b10 : 2'b01);
               check("rd_data_m0", m0_readdata, mon_rd.data);
               check("rd_data_m1", m1_readdata, mon_rd.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset_reset_n = 0;
      m0_address = 0; m0_read = 0; m0_write = 0; m0_writedata = 0; m0_byteenable = 4'hF;
      m1_address = 0; m1_read = 0; m1_write = 0; m1_writedata = 0; m1_byteenable = 4'hF;
      s_waitrequest = 0; s_readdata = 0; s_readdatavalid = 0;

      // single m0 read, return 3 cycles later
      do_reset();
      m0_read = 1; m0_address = 25'h10;
      push_cmd(25'h10, 0, 0);
      #3;
      check("t1_m0_wait", m0_waitrequest, 0);
      check("t1_s_read", s_read, 1);
      tick();
      m0_read = 0;
      #3;
      check("t1_pending1", pending, 1);
      tick();
      tick();
      s_readdatavalid = 1; s_readdata = 32'hDEADBEEF;
      push_rd(0, 32'hDEADBEEF);
      #3;
      check("t1_m1_rdv", m1_readdatavalid, 0);
      tick();
      s_readdatavalid = 0;
      #3;
      check("t1_pending0", pending, 0);

      // both masters read continuously: m0, m1, m0, m1
      do_reset();
      m0_read = 1; m0_address = 25'h20;
      m1_read = 1; m1_address = 25'h40;
      for (int i = 0; i < 4; i++) push_cmd((i % 2) ? 25'h40 : 25'h20, 0, 0);
      for (int i = 0; i < 4; i++) begin
         #3;
         check("t2_m0_wait", m0_waitrequest, (i % 2));
         check("t2_m1_wait", m1_waitrequest, !(i % 2));
         tick();
      end
      m0_read = 0; m1_read = 0;
      #3;
      check("t2_pending4", pending, 4);
      for (int i = 0; i < 4; i++) begin
         tick();
         s_readdatavalid = 1; s_readdata = 32'hA000_0000 + i;
         push_rd(i % 2, 32'hA000_0000 + i);
      end
      tick();
      s_readdatavalid = 0;
      #3;
      check("t2_pending0", pending, 0);

      // m1 write stalled 4 cycles while m0 waits
      do_reset();
      s_waitrequest = 1;
      m1_write = 1; m1_address = 25'h100; m1_writedata = 32'h1234_5678; m1_byteenable = 4'hF;
      push_cmd(25'h100, 1, 32'h1234_5678);
      #3;
      check("t3_s_write0", s_write, 1);
      check("t3_m1_wait0", m1_waitrequest, 1);
      tick();
      m0_read = 1; m0_address = 25'h30;
      push_cmd(25'h30, 0, 0);
      for (int i = 0; i < 3; i++) begin
         #3;
         check("t3_s_addr_stable", s_address, 25'h100);
         check("t3_s_write_stable", {s_write, s_read}, 2'b10);
         check("t3_s_wdata_stable", s_writedata, 32'h1234_5678);
         check("t3_s_be_stable", s_byteenable, 4'hF);
         check("t3_m0_wait_lock", m0_waitrequest, 1);
         tick();
      end
      s_waitrequest = 0;
      #3;
      check("t3_m1_accept", m1_waitrequest, 0);
      check("t3_m0_wait_acc", m0_waitrequest, 1);
      tick();
      m1_write = 0;
      #3;
      check("t3_m0_granted", m0_waitrequest, 0);
      check("t3_m0_addr", s_address, 25'h30);
      tick();
      m0_read = 0;
      s_readdatavalid = 1; s_readdata = 32'hC0DE_0030;
      push_rd(0, 32'hC0DE_0030);
      tick();
      s_readdatavalid = 0;

      // m0 fills the read FIFO; 9th stalls; m1 write gets through
      do_reset();
      m0_read = 1;
      for (int i = 0; i < 8; i++) begin
         m0_address = 25'h200 + i;
         push_cmd(25'h200 + i, 0, 0);
         tick();
      end
      m0_address = 25'h208;
      m1_write = 1; m1_address = 25'h300; m1_writedata = 32'h55AA_55AA; m1_byteenable = 4'h3;
      push_cmd(25'h300, 1, 32'h55AA_55AA);
      #3;
      check("t4_pending8", pending, 8);
      check("t4_m0_stall", m0_waitrequest, 1);
      check("t4_m1_write_acc", m1_waitrequest, 0);
      check("t4_s_be", s_byteenable, 4'h3);
      tick();
      m1_write = 0;
      #3;
      check("t4_m0_still_stall", m0_waitrequest, 1);
      check("t4_s_read_blocked", s_read, 0);
      tick();
      s_readdatavalid = 1; s_readdata = 32'hB000_0000;
      push_rd(0, 32'hB000_0000);
      push_cmd(25'h208, 0, 0);
      #3;
      check("t4_m0_unblock", m0_waitrequest, 0);
      tick();

      // return + new m1 read at count 8
      m0_read = 0;
      m1_read = 1; m1_address = 25'h400;
      s_readdata = 32'hB000_0001;
      push_rd(0, 32'hB000_0001);
      push_cmd(25'h400, 0, 0);
      #3;
      check("t5_pending8a", pending, 8);
      check("t5_m1_acc", m1_waitrequest, 0);
      tick();
      m1_read = 0; s_readdatavalid = 0;
      #3;
      check("t5_pending8b", pending, 8);
      for (int i = 0; i < 8; i++) begin
         s_readdatavalid = 1; s_readdata = 32'hB000_0002 + i;
         push_rd(i == 7, 32'hB000_0002 + i);
         tick();
      end
      s_readdatavalid = 0;
      #3;
      check("t5_pending0", pending, 0);

      // orphan return
      do_reset();
      s_readdatavalid = 1; s_readdata = 32'h0000_0BAD;
      #3;
      check("t6_no_strobe", {m1_readdatavalid, m0_readdatavalid}, 0);
      check("t6_pending", pending, 0);
      tick();
      s_readdatavalid = 0;
      #3;
      check("t6_orphan_set", err_orphan, 1);
      tick();
      tick();
      check("t6_orphan_sticky", err_orphan, 1);
      do_reset();
      #3;
      check("t6_orphan_clr", err_orphan, 0);

      tick();
      check("cmd_queue_empty", exp_cmd.size(), 0);
      check("rd_queue_empty", exp_rd.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
